// File: rtl/txpause.sv
// 802.3x PAUSE inserter on the 64-bit TX stream: XOFF/XON frames at packet boundaries, user frames held while partner-paused.
// One bubble per IDLE decision; DATA is a zero-latency pass-through; PAUSE beats hold under m_tready low.
module txpause (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_tx_pause_enable,
  input  logic [47:0] cfg_src_mac,
  input  logic [15:0] cfg_pause_quanta,
  input  logic [23:0] cfg_refresh_cycles,
  input  logic        pause_req,
  input  logic        rx_pause_active,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        tx_pause_sent
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAUSE
  } state_t;

  state_t      state_q, state_d;
  logic        pause_req_q, pause_req_d;
  logic        xoff_pend_q, xoff_pend_d;
  logic        xon_pend_q, xon_pend_d;
  logic [23:0] timer_q, timer_d;
  logic [2:0]  beat_q, beat_d;
  logic [15:0] quanta_q, quanta_d;

  logic        start_pause;
  logic        req_rise, req_fall;
  logic        refresh_on, refresh_hit;
  logic [63:0] pause_beat;

  always_comb begin
    pause_req_d = pause_req;
    req_rise    = pause_req & ~pause_req_q;
    req_fall    = ~pause_req & pause_req_q;
    refresh_on  = pause_req & cfg_tx_pause_enable & (cfg_refresh_cycles != 24'd0);
    refresh_hit = refresh_on & (timer_q == cfg_refresh_cycles - 24'd1);

    if (req_rise || refresh_hit || !refresh_on) begin
      timer_d = 24'd0;
    end else begin
      timer_d = timer_q + 24'd1;
    end

    xoff_pend_d = xoff_pend_q;
    xon_pend_d  = xon_pend_q;
    // Consume first so that an edge landing on the entry cycle still queues a new frame.
    if (start_pause) begin
      if (xon_pend_q) begin
        xon_pend_d = 1'b0;
      end else begin
        xoff_pend_d = 1'b0;
      end
    end
    if (req_rise || refresh_hit) begin
      xoff_pend_d = 1'b1;
    end
    if (req_rise) begin
      xon_pend_d = 1'b0;
    end
    if (req_fall) begin
      xon_pend_d  = 1'b1;
      xoff_pend_d = 1'b0;
    end
    if (!cfg_tx_pause_enable) begin
      xoff_pend_d = 1'b0;
      xon_pend_d  = 1'b0;
    end
  end

  // Byte n of a beat sits at [8n+7:8n]; SA byte 0 is cfg_src_mac[47:40].
  always_comb begin
    pause_beat = 64'd0;
    case (beat_q)
      3'd0: pause_beat = {cfg_src_mac[39:32], cfg_src_mac[47:40],
                          8'h01, 8'h00, 8'h00, 8'hC2, 8'h80, 8'h01};
      3'd1: pause_beat = {8'h01, 8'h00, 8'h08, 8'h88,
                          cfg_src_mac[7:0], cfg_src_mac[15:8],
                          cfg_src_mac[23:16], cfg_src_mac[31:24]};
      3'd2: pause_beat = {48'd0, quanta_q[7:0], quanta_q[15:8]};
      default: pause_beat = 64'd0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    quanta_d      = quanta_q;
    start_pause   = 1'b0;
    s_tready      = 1'b0;
    m_tvalid      = 1'b0;
    m_tdata       = 64'd0;
    m_tkeep       = 8'd0;
    m_tlast       = 1'b0;
    tx_pause_sent = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_tx_pause_enable && (xoff_pend_q || xon_pend_q)) begin
          state_d     = ST_PAUSE;
          start_pause = 1'b1;
          beat_d      = 3'd0;
          quanta_d    = xon_pend_q ? 16'h0000 : cfg_pause_quanta;
        end else if (s_tvalid && !rx_pause_active) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        m_tdata  = s_tdata;
        m_tkeep  = s_tkeep;
        m_tvalid = s_tvalid;
        m_tlast  = s_tlast;
        s_tready = m_tready;
        if (s_tvalid && m_tready && s_tlast) begin
          state_d = ST_IDLE;
        end
      end
      ST_PAUSE: begin
        m_tvalid = 1'b1;
        m_tdata  = pause_beat;
        m_tkeep  = (beat_q == 3'd7) ? 8'h0F : 8'hFF;
        m_tlast  = (beat_q == 3'd7);
        if (m_tready) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d       = ST_IDLE;
            tx_pause_sent = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pause_req_q <= 1'b0;
      xoff_pend_q <= 1'b0;
      xon_pend_q  <= 1'b0;
      timer_q     <= 24'd0;
      beat_q      <= 3'd0;
      quanta_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      pause_req_q <= pause_req_d;
      xoff_pend_q <= xoff_pend_d;
      xon_pend_q  <= xon_pend_d;
      timer_q     <= timer_d;
      beat_q      <= beat_d;
      quanta_q    <= quanta_d;
    end
  end

endmodule

// File: tb/tb_txpause.sv
// Directed bench for txpause: expected output beats are queued from byte-level frame images and user packets.
module tb_txpause;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_tx_pause_enable;
  logic [47:0] cfg_src_mac;
  logic [15:0] cfg_pause_quanta;
  logic [23:0] cfg_refresh_cycles;
  logic        pause_req;
  logic        rx_pause_active;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        tx_pause_sent;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        pl;
  } beat_t;

  beat_t exp_q[$];
  beat_t user_q[$];
  int    sent_cyc[$];
  int    vectors = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    n_sent  = 0;
  int    n_hs    = 0;
  bit    rand_rdy = 1'b0;

  localparam logic [47:0] SRC_MAC = 48'h001122334455;

  txpause dut (
    .clk(clk), .rst(rst),
    .cfg_tx_pause_enable(cfg_tx_pause_enable), .cfg_src_mac(cfg_src_mac),
    .cfg_pause_quanta(cfg_pause_quanta), .cfg_refresh_cycles(cfg_refresh_cycles),
    .pause_req(pause_req), .rx_pause_active(rx_pause_active),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .tx_pause_sent(tx_pause_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Frame image: 60 bytes, split into 8-byte beats, byte n at [8n+7:8n].
  function automatic void push_pause(input logic [15:0] q);
    logic [7:0]  fb [0:63];
    logic [47:0] sa;
    beat_t       e;
    sa = SRC_MAC;
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    fb[0] = 8'h01; fb[1] = 8'h80; fb[2] = 8'hC2;
    fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h01;
    for (int i = 0; i < 6; i++) fb[6+i] = sa[47-8*i -: 8];
    fb[12] = 8'h88; fb[13] = 8'h08; fb[14] = 8'h00; fb[15] = 8'h01;
    fb[16] = q[15:8]; fb[17] = q[7:0];
    for (int b = 0; b < 8; b++) begin
      e.d = 64'd0;
      e.k = 8'd0;
      for (int n = 0; n < 8; n++) begin
        if (8*b + n < 60) begin
          e.d[8*n +: 8] = fb[8*b+n];
          e.k[n] = 1'b1;
        end
      end
      e.l  = (b == 7);
      e.pl = (b == 7);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void push_user(input int nb, input logic [7:0] last_keep);
    beat_t e;
    for (int b = 0; b < nb; b++) begin
      e.d  = {$urandom, $urandom};
      e.l  = (b == nb - 1);
      e.k  = e.l ? last_keep : 8'hFF;
      e.pl = 1'b0;
      user_q.push_back(e);
      exp_q.push_back(e);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input string name, input int lvl);
    int i;
    i = 0;
    while (exp_q.size() > lvl && i < 5000) begin
      @(posedge clk);
      i++;
    end
    #1;
    vectors++;
    if (exp_q.size() > lvl) begin
      errors++;
      $display("FAIL %s: %0d beats still outstanding after timeout, required <= %0d", name, exp_q.size(), lvl);
      exp_q.delete();
    end
  endtask

  task automatic wait_drain(input string name);
    wait_level(name, 0);
    tick(3);
  endtask

  // User source and MAC ready: change only just after the rising edge.
  initial begin
    bit hs;
    s_tvalid = 1'b0; s_tdata = 64'd0; s_tkeep = 8'd0; s_tlast = 1'b0;
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = s_tvalid && s_tready && !rst;
      @(posedge clk);
      #1;
      if (hs && user_q.size() > 0) void'(user_q.pop_front());
      if (user_q.size() > 0) begin
        s_tvalid = 1'b1;
        s_tdata  = user_q[0].d;
        s_tkeep  = user_q[0].k;
        s_tlast  = user_q[0].l;
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = 64'd0;
        s_tkeep  = 8'd0;
        s_tlast  = 1'b0;
      end
      m_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Compare process: every accepted beat against the expected queue, plus AXIS hold.
  initial begin
    bit          pv, pr, pl;
    logic [63:0] pd;
    logic [7:0]  pk;
    beat_t       e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 64'd0; pk = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          vectors++;
          if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl) begin
            errors++;
            $display("FAIL axis_hold: got v=%b d=%h k=%h l=%b required v=1 d=%h k=%h l=%b",
                     m_tvalid, m_tdata, m_tkeep, m_tlast, pd, pk, pl);
          end
        end
        vectors++;
        if (m_tvalid && m_tready) begin
          n_hs++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got d=%h k=%h l=%b required no beat", m_tdata, m_tkeep, m_tlast);
          end else begin
            e = exp_q.pop_front();
            if (m_tdata !== e.d || m_tkeep !== e.k || m_tlast !== e.l || tx_pause_sent !== e.pl) begin
              errors++;
              $display("FAIL beat: got d=%h k=%h l=%b sent=%b required d=%h k=%h l=%b sent=%b",
                       m_tdata, m_tkeep, m_tlast, tx_pause_sent, e.d, e.k, e.l, e.pl);
            end
          end
        end else if (tx_pause_sent !== 1'b0) begin
          errors++;
          $display("FAIL sent_no_hs: got tx_pause_sent=%b required 0", tx_pause_sent);
        end
        if (tx_pause_sent) begin
          n_sent++;
          sent_cyc.push_back(cyc);
        end
        pv = m_tvalid; pr = m_tready; pd = m_tdata; pk = m_tkeep; pl = m_tlast;
      end
    end
  end

  initial begin
    int  base, n0, h0;
    bit  saw;
    cfg_tx_pause_enable = 1'b1;
    cfg_src_mac         = SRC_MAC;
    cfg_pause_quanta    = 16'h1234;
    cfg_refresh_cycles  = 24'd0;
    pause_req           = 1'b0;
    rx_pause_active     = 1'b0;
    rst                 = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
    chk("rst_m_tkeep", {56'd0, m_tkeep}, 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_sent", {63'd0, tx_pause_sent}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(3);

    // XOFF from idle: two bubble cycles, then beat 0 at N+2.
    push_pause(16'h1234);
    pause_req = 1'b1;
    @(negedge clk); chk("lat_n0_valid", {63'd0, m_tvalid}, 64'd0);
    @(negedge clk); chk("lat_n1_valid", {63'd0, m_tvalid}, 64'd0);
    @(negedge clk); chk("lat_n2_valid", {63'd0, m_tvalid}, 64'd1);
    chk("xoff_beat0", m_tdata, 64'h1100_0100_00C2_8001);
    @(negedge clk); chk("xoff_beat1", m_tdata, 64'h0100_0888_5544_3322);
    @(negedge clk); chk("xoff_beat2_quanta", {48'd0, m_tdata[15:0]}, 64'h3412);
    wait_drain("xoff1");
    chk("xoff1_sent", n_sent, 1);
    tick(20);

    // XON on release, then silence.
    push_pause(16'h0000);
    pause_req = 1'b0;
    wait_drain("xon1");
    tick(50);
    chk("xon1_sent", n_sent, 2);

    // Enable low swallows edges; re-enabling without an edge sends nothing.
    cfg_tx_pause_enable = 1'b0;
    pause_req = 1'b1;
    tick(30);
    cfg_tx_pause_enable = 1'b1;
    tick(30);
    cfg_tx_pause_enable = 1'b0;
    pause_req = 1'b0;
    tick(3);
    cfg_tx_pause_enable = 1'b1;
    tick(20);
    chk("enable_low_sent", n_sent, 2);

    // Refresh every 1000 cycles while held.
    cfg_refresh_cycles = 24'd1000;
    base = sent_cyc.size();
    push_pause(16'h1234); push_pause(16'h1234); push_pause(16'h1234);
    pause_req = 1'b1;
    tick(2050);
    vectors++;
    if (sent_cyc.size() < base + 3) begin
      errors++;
      $display("FAIL refresh_count: got %0d frames required 3", sent_cyc.size() - base);
    end else begin
      chk("refresh_gap1", sent_cyc[base+1] - sent_cyc[base], 1000);
      chk("refresh_gap2", sent_cyc[base+2] - sent_cyc[base+1], 1000);
    end
    push_pause(16'h0000);
    pause_req = 1'b0;
    wait_drain("refresh_xon");

    // Refresh disabled: exactly one XOFF over a long hold.
    cfg_refresh_cycles = 24'd0;
    n0 = n_sent;
    push_pause(16'h1234);
    pause_req = 1'b1;
    tick(2100);
    push_pause(16'h0000);
    pause_req = 1'b0;
    wait_drain("norefresh");
    chk("norefresh_sent", n_sent - n0, 2);

    // Request mid user packet: packet A completes, XOFF, then queued packet B.
    push_user(10, 8'hFF);
    push_pause(16'h1234);
    push_user(3, 8'h3F);
    tick(5);
    pause_req = 1'b1;
    wait_drain("midpkt");
    push_pause(16'h0000);
    pause_req = 1'b0;
    wait_drain("midpkt_xon");

    // Partner pause blocks user data but not our own pause frame.
    rx_pause_active = 1'b1;
    push_pause(16'h1234);
    push_user(2, 8'h01);
    pause_req = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (s_tready) saw = 1'b1;
    end
    @(posedge clk); #1;
    chk("rxpause_s_tready", {63'd0, saw}, 64'd0);
    chk("rxpause_left", exp_q.size(), 2);
    rx_pause_active = 1'b0;
    wait_drain("rxpause_user");
    push_pause(16'h0000);
    pause_req = 1'b0;
    wait_drain("rxpause_xon");

    // Random backpressure; quanta changes mid-frame must not leak in.
    rand_rdy = 1'b1;
    cfg_pause_quanta = 16'hBEEF;
    n0 = n_sent;
    h0 = n_hs;
    push_pause(16'hBEEF);
    pause_req = 1'b1;
    wait_level("bp_mid", 6);
    cfg_pause_quanta = 16'h5555;
    wait_drain("bp_xoff");
    chk("bp_handshakes", n_hs - h0, 8);
    chk("bp_sent", n_sent - n0, 1);
    push_user(4, 8'h0F);
    wait_drain("bp_user");
    push_pause(16'h0000);
    pause_req = 1'b0;
    wait_drain("bp_xon");

    // Reset mid-frame; request still high at release counts as a fresh edge.
    push_pause(16'h5555);
    pause_req = 1'b1;
    wait_level("rst_mid", 4);
    rst = 1'b1;
    exp_q.delete();
    push_pause(16'h5555);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_valid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_abort_last", {63'd0, m_tlast}, 64'd0);
    wait_drain("post_rst_xoff");
    rand_rdy = 1'b0;
    push_pause(16'h0000);
    pause_req = 1'b0;
    wait_drain("post_rst_xon");
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/txpause.md
# txpause

Transmit-side IEEE 802.3x PAUSE generator. It sits on the 64-bit TX AXI-Stream path between the user and the MAC TX datapath. At packet boundaries it inserts XOFF frames (quanta = cfg value) and XON frames (quanta = 0), driven by a local congestion request. It also holds off user frames while the link partner has paused us (`rx_pause_active` from the RX pause detector).

## Interface
- No parameters.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_tx_pause_enable`  in  1  enables PAUSE generation.
- `cfg_src_mac`  in  48  our MAC SA; [47:40] is the first byte on the wire.
- `cfg_pause_quanta`  in  16  quanta carried in XOFF frames.
- `cfg_refresh_cycles`  in  24  XOFF resend interval in clk cycles; 0 disables refresh.
- `pause_req`  in  1  level; high = local RX congested.
- `rx_pause_active`  in  1  partner pause in effect; gates user frames only.
- `s_tdata`/`s_tkeep`/`s_tvalid`/`s_tlast`  in  64/8/1/1  user TX stream.
- `s_tready`  out  1  user stream ready.
- `m_tdata`/`m_tkeep`/`m_tvalid`/`m_tlast`  out  64/8/1/1  stream to MAC.
- `m_tready`  in  1  MAC ready.
- `tx_pause_sent`  out  1  one-cycle pulse on the last beat handshake of each generated frame.

## Operation
- Byte n of a beat is `tdata[8n+7:8n]`.
- A generated frame is 60 bytes without FCS; the MAC appends the FCS. It is sent as 8 beats, where beats 0–6 have tkeep 8'hFF and beat 7 has tkeep 8'h0F with tlast set.
- Frame bytes:
  - bytes 0–5: DA 01 80 C2 00 00 01
  - bytes 6–11: SA
  - bytes 12–13: 88 08
  - bytes 14–15: opcode 00 01
  - bytes 16–17: quanta, MSB first
  - bytes 18–59: 00
- Request tracking:
  - `pause_req_q` holds the previous-cycle value of `pause_req`.
  - Rising edge: set `xoff_pend`, clear `xon_pend`, zero the refresh timer.
  - Falling edge: set `xon_pend`, clear `xoff_pend`.
- Refresh timer:
  - Counts only while `pause_req` is high, enable is high and `cfg_refresh_cycles` != 0.
  - When the count equals `cfg_refresh_cycles`-1: set `xoff_pend` and wrap the timer to 0.
- Enable low:
  - Both pends cleared, timer held at 0.
  - A frame already in flight (pause or user) completes.
- State machine:
  - IDLE:
    - `s_tready`=0, `m_tvalid`=0.
    - If enable is high and a pend is set, go to PAUSE. At entry, snapshot the quanta (`xon_pend` → 0, else `cfg_pause_quanta`), clear the consumed pend and zero the beat counter.
    - Otherwise, if `s_tvalid` is high and `rx_pause_active` is low, go to DATA.
    - Pause has priority over user data.
  - DATA:
    - Combinational pass-through: `m_*`=`s_*`, `s_tready`=`m_tready`.
    - On `s_tvalid`&`m_tready`&`s_tlast`, go to IDLE.
    - `rx_pause_active` rising mid-packet does not interrupt the packet.
  - PAUSE:
    - `m_tvalid`=1 with beat data from the counter; `s_tready`=0.
    - The counter advances on `m_tready`.
    - On the beat-7 handshake: go to IDLE and pulse `tx_pause_sent`.
- Edges and refresh expiries during PAUSE or DATA set pends for a later frame and are never lost.
- SA and quanta are stable for the whole frame: the quanta is snapshotted at entry. `cfg_src_mac` is static config.

## Timing
- Reset values:
  - `m_tvalid`=0, `s_tready`=0, `m_tlast`=0, `m_tkeep`=0, `m_tdata`=0, `tx_pause_sent`=0.
  - State IDLE, pends 0, timer 0, `pause_req_q`=0.
- `pause_req` high at reset release counts as a rising edge.
- Latency: an edge at cycle N sets the pend at N+1. If the state is IDLE, PAUSE is entered at N+2 with beat 0 valid.
- Each IDLE→DATA or IDLE→PAUSE decision costs one bubble cycle.
- Data path latency in DATA: 0 cycles. Throughput at `m_tready`=1: 1 beat/cycle.
- AXIS rule: while `m_tvalid`=1 and `m_tready`=0, all `m_*` signals hold.
- `rst` mid-frame aborts immediately: `m_tvalid` drops the next cycle and no `tlast` is emitted.

## Test plan
- Enable=1, quanta 16'h1234, `pause_req` 0→1 while idle → one frame, 8 beats.
  - Beat 0 = 64'h????_0100_00C2_8001 with SA 00:11:22:33:44:55, i.e. 64'h1100_0100_00C2_8001.
  - Beat 1 bytes 12–15 = 88 08 00 01.
  - Beat 2 [15:0] = 16'h3412.
  - Beat 7 tkeep 8'h0F with tlast; one `tx_pause_sent` pulse.
- `pause_req` 1→0 → frame with bytes 16–17 = 00 00; no further frames.
- `cfg_refresh_cycles`=1000 with `pause_req` held → XOFF frames start 1000 cycles apart; with refresh 0 → exactly one frame.
- `pause_req` rises mid 10-beat user packet → user packet completes unbroken, then the XOFF frame follows; a queued user packet goes after the XOFF.
- `rx_pause_active`=1 with user data pending → `s_tready` stays 0, while a pause request still emits its frame.
- Random `m_tready` backpressure during a pause frame → data and keep held per beat, exactly 8 handshakes; `rst` mid-frame → `m_tvalid`=0 the next cycle.
